// File: rtl/tratador_botoes.sv
// Button input conditioning: two-flop synchronisers, per-button debounce and
// a press-classification FSM that emits one registered event pulse per gesture
// (short press, long press, or both buttons).
//
// Handshake: none. Every event output is a single-cycle pulse with no
// back-pressure. The consumer samples all event outputs every cycle.
// At most one event is high in any cycle.
module tratador_botoes #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       b1,
    input  logic       b2,
    output logic       b1_estavel,
    output logic       b2_estavel,
    output logic       b1_curto,
    output logic       b2_curto,
    output logic       b1_longo,
    output logic       b2_longo,
    output logic       ambos,
    output logic [2:0] estado_dbg
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE   = DW'(1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    // Bit positions inside the event register.
    localparam int EV_C1 = 0;
    localparam int EV_C2 = 1;
    localparam int EV_L1 = 2;
    localparam int EV_L2 = 3;
    localparam int EV_AM = 4;

    typedef enum logic [2:0] {
        S_OCIOSO = 3'd0,
        S_PRESS1 = 3'd1,
        S_PRESS2 = 3'd2,
        S_AMBOS  = 3'd3,
        S_ESPERA = 3'd4
    } estado_t;

    // Index 0 is button 1 and index 1 is button 2 throughout.
    logic [1:0]    raw;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    estavel_q;
    logic [1:0]    estavel_d;
    logic [1:0]    prev_q;
    logic [DW-1:0] deb_cnt_q [2];
    logic [DW-1:0] deb_cnt_d [2];

    estado_t       state_q;
    estado_t       state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;
    logic [4:0]    ev_q;
    logic [4:0]    ev_d;

    logic [1:0]    rise;
    logic [1:0]    fall;

    assign raw = {b2, b1};

    // Debounce: accept a new level only after it has differed from the
    // stable level for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        estavel_d    = estavel_q;
        deb_cnt_d[0] = '0;
        deb_cnt_d[1] = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != estavel_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    estavel_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DEB_ONE;
                end
            end
        end
    end

    // Synchroniser flops, debounce state and the edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            estavel_q <= '0;
            prev_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            estavel_q <= estavel_d;
            prev_q    <= estavel_q;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign rise = estavel_q & ~prev_q;
    assign fall = ~estavel_q & prev_q;

    // Classification: next state, hold counter and event to emit. The hold
    // counter only runs while a single button is held and is zero elsewhere.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        ev_d    = '0;
        case (state_q)
            S_OCIOSO: begin
                if (rise == 2'b11) begin
                    state_d     = S_AMBOS;
                    ev_d[EV_AM] = 1'b1;
                end else if (rise[0]) begin
                    state_d = S_PRESS1;
                end else if (rise[1]) begin
                    state_d = S_PRESS2;
                end
            end
            S_PRESS1: begin
                if (rise[1]) begin
                    state_d     = S_AMBOS;
                    ev_d[EV_AM] = 1'b1;
                end else if (fall[0]) begin
                    state_d     = S_OCIOSO;
                    ev_d[EV_C1] = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    state_d     = S_ESPERA;
                    ev_d[EV_L1] = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            S_PRESS2: begin
                if (rise[0]) begin
                    state_d     = S_AMBOS;
                    ev_d[EV_AM] = 1'b1;
                end else if (fall[1]) begin
                    state_d     = S_OCIOSO;
                    ev_d[EV_C2] = 1'b1;
                end else if (hold_q == HOLD_LAST) begin
                    state_d     = S_ESPERA;
                    ev_d[EV_L2] = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            S_AMBOS: begin
                // The ambos pulse is already on the output during this state.
                state_d = S_ESPERA;
            end
            S_ESPERA: begin
                if (estavel_q == 2'b00) begin
                    state_d = S_OCIOSO;
                end
            end
            default: begin
                state_d = S_OCIOSO;
            end
        endcase
    end

    // FSM state, hold counter and registered event outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_OCIOSO;
            hold_q  <= '0;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ev_q    <= ev_d;
        end
    end

    assign b1_estavel = estavel_q[0];
    assign b2_estavel = estavel_q[1];
    assign b1_curto   = ev_q[EV_C1];
    assign b2_curto   = ev_q[EV_C2];
    assign b1_longo   = ev_q[EV_L1];
    assign b2_longo   = ev_q[EV_L2];
    assign ambos      = ev_q[EV_AM];
    assign estado_dbg = state_q;

endmodule

// File: tb/tb_tratador_botoes.sv
// Bench for tratador_botoes with DEBOUNCE_CYCLES=4 and LONG_CYCLES=10.
// Inputs are driven just after the falling edge. Outputs are sampled on the
// falling edge. cyc counts rising edges.
module tb_tratador_botoes;

    localparam int DEB  = 4;
    localparam int LNG  = 10;
    localparam int IDLE = 25;

    // Event codes: {ambos, b2_longo, b1_longo, b2_curto, b1_curto}
    localparam logic [4:0] EV_C1 = 5'b00001;
    localparam logic [4:0] EV_C2 = 5'b00010;
    localparam logic [4:0] EV_L1 = 5'b00100;
    localparam logic [4:0] EV_L2 = 5'b01000;
    localparam logic [4:0] EV_AM = 5'b10000;
    localparam logic [4:0] EV_NO = 5'b00000;

    logic       clk = 1'b0;
    logic       reset;
    logic       b1;
    logic       b2;
    logic       b1_estavel;
    logic       b2_estavel;
    logic       b1_curto;
    logic       b2_curto;
    logic       b1_longo;
    logic       b2_longo;
    logic       ambos;
    logic [2:0] estado_dbg;

    tratador_botoes #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .b1        (b1),
        .b2        (b2),
        .b1_estavel(b1_estavel),
        .b2_estavel(b2_estavel),
        .b1_curto  (b1_curto),
        .b2_curto  (b2_curto),
        .b1_longo  (b1_longo),
        .b2_longo  (b2_longo),
        .ambos     (ambos),
        .estado_dbg(estado_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: {event code, cycle at which it must be seen}
    logic [36:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Vector table: press windows are relative to the gesture start.
    // A length of 0 means the button is not pressed.
    typedef struct {
        int         b1_on;
        int         b1_len;
        int         b2_on;
        int         b2_len;
        logic [4:0] evt;
        int         off;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Advance one cycle and match any event pulse against the scoreboard.
    task automatic tick();
        logic [4:0]  evt;
        logic [36:0] e;
        @(negedge clk);
        evt = {ambos, b2_longo, b1_longo, b2_curto, b1_curto};
        if (evt !== EV_NO) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: got %b at cyc %0d, expected none", evt, cyc);
            end else begin
                e = exp_q.pop_front();
                check("event_code", 32'(evt), 32'(e[36:32]));
                check("event_cycle", 32'(cyc), e[31:0]);
            end
        end
    endtask

    // Any expected event still queued was never produced.
    task automatic drain(input string name);
        logic [36:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missing_event %s: got nothing, expected %b at cyc %0d", name, e[36:32], e[31:0]);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int span;
        int hi1;
        int hi2;
        n    = cyc;
        span = (v.b1_on + v.b1_len > v.b2_on + v.b2_len) ? v.b1_on + v.b1_len : v.b2_on + v.b2_len;
        hi1  = 0;
        hi2  = 0;
        if (v.evt != EV_NO) exp_q.push_back({v.evt, 32'(n + v.off)});
        for (int t = 0; t < span + IDLE; t++) begin
            b1 = (t >= v.b1_on) && (t < v.b1_on + v.b1_len);
            b2 = (t >= v.b2_on) && (t < v.b2_on + v.b2_len);
            tick();
            if (b1_estavel) hi1++;
            if (b2_estavel) hi2++;
        end
        check($sformatf("v%0d_b1_estavel_cycles", idx), 32'(hi1), 32'((v.b1_len >= DEB) ? v.b1_len : 0));
        check($sformatf("v%0d_b2_estavel_cycles", idx), 32'(hi2), 32'((v.b2_len >= DEB) ? v.b2_len : 0));
        check($sformatf("v%0d_idle_state", idx), 32'(estado_dbg), 32'd0);
        drain($sformatf("v%0d", idx));
    endtask

    initial begin
        int m;
        int hi1;
        int n_bounce;
        int len;

        vecs[0]  = '{0, 7,  0, 0,  EV_C1, 14};  // short b1
        vecs[1]  = '{0, 0,  0, 4,  EV_C2, 11};  // shortest accepted b2 press
        vecs[2]  = '{0, 0,  0, 30, EV_L2, 17};  // long b2
        vecs[3]  = '{0, 11, 0, 0,  EV_L1, 17};  // long b1, just past the limit
        vecs[4]  = '{0, 10, 0, 0,  EV_C1, 17};  // release lands on hold limit
        vecs[5]  = '{0, 23, 3, 20, EV_AM, 10};  // b1 then b2 three cycles later
        vecs[6]  = '{0, 20, 0, 20, EV_AM, 7};   // both in the same cycle
        vecs[7]  = '{2, 13, 0, 15, EV_AM, 9};   // b2 then b1
        vecs[8]  = '{0, 30, 15, 10, EV_L1, 17}; // b2 after long press is ignored
        vecs[9]  = '{0, 8,  2, 3,  EV_C1, 15};  // b2 glitch during b1 press
        vecs[10] = '{0, 0,  0, 10, EV_C2, 17};  // b2 release on hold limit
        vecs[11] = '{0, 0,  0, 11, EV_L2, 17};  // b2 just past the limit

        // Reset with both buttons held
        reset = 1'b1;
        b1    = 1'b0;
        b2    = 1'b0;
        repeat (3) tick();
        b1 = 1'b1;
        b2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("reset_outputs",
                  32'({b1_estavel, b2_estavel, b1_curto, b2_curto, b1_longo, b2_longo, ambos}), 32'd0);
        end
        check("reset_state", 32'(estado_dbg), 32'd0);

        reset = 1'b0;
        m     = cyc;
        exp_q.push_back({EV_AM, 32'(m + 7)});
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cyc == m + 5) begin
                check("post_reset_b1_estavel_early", 32'(b1_estavel), 32'd0);
                check("post_reset_b2_estavel_early", 32'(b2_estavel), 32'd0);
            end
            if (cyc == m + 6) begin
                check("post_reset_b1_estavel_rise", 32'(b1_estavel), 32'd1);
                check("post_reset_b2_estavel_rise", 32'(b2_estavel), 32'd1);
            end
        end
        b1 = 1'b0;
        b2 = 1'b0;
        repeat (IDLE) tick();
        check("post_reset_idle_state", 32'(estado_dbg), 32'd0);
        drain("reset_press");

        // Bounce rejection: pulses of 1-3 cycles separated by 1-3 cycle lows
        hi1      = 0;
        n_bounce = 0;
        while (n_bounce < 40) begin
            len = $urandom_range(1, DEB - 1);
            for (int k = 0; k < len; k++) begin
                b1 = 1'b1;
                tick();
                if (b1_estavel) hi1++;
            end
            n_bounce += len;
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) begin
                b1 = 1'b0;
                tick();
                if (b1_estavel) hi1++;
            end
            n_bounce += len;
        end
        b1 = 1'b0;
        for (int k = 0; k < IDLE; k++) begin
            tick();
            if (b1_estavel) hi1++;
        end
        check("bounce_b1_estavel_cycles", 32'(hi1), 32'd0);
        check("bounce_idle_state", 32'(estado_dbg), 32'd0);
        drain("bounce");

        // Table-driven gestures
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
